// File: rtl/btn_event_ctrl_pkg.sv
// Shared types, event-kind constants and width helper for the button event controller.
package btn_pkg;

    // Per-channel press/hold/repeat state.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } chan_state_e;

    localparam logic EVT_PRESS  = 1'b0;
    localparam logic EVT_REPEAT = 1'b1;

    // Ceiling log2, never less than one bit so counters/ids stay legal for tiny values.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((64'd1 << width) < 64'(value)) width++;
        return width;
    endfunction

endpackage

// File: rtl/btn_event_ctrl_if.sv
// Valid/ready event port: the controller drives id/kind, the consumer drives ready.
interface btn_event_ctrl_if #(
    parameter int unsigned ID_W = 3
);
    logic            evt_valid;
    logic [ID_W-1:0] evt_id;
    logic            evt_repeat;
    logic            evt_ready;

    modport master (output evt_valid, evt_id, evt_repeat, input evt_ready);
    modport slave  (input evt_valid, evt_id, evt_repeat, output evt_ready);
endinterface

// File: rtl/btn_debounce_chan.sv
// One button channel: 2-FF synchroniser, tick-based debounce and press/hold/repeat FSM.
// evt_set/evt_kind are combinational so the top can latch a pending event on the
// same edge that the debounced level or hold counter changes.
module btn_debounce_chan
    import btn_pkg::*;
#(
    parameter int unsigned STABLE_LEN   = 11,
    parameter int unsigned HOLD_TICKS   = 50,
    parameter int unsigned REPEAT_TICKS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic sample_tick,
    input  logic repeat_en,
    output logic level,
    output logic evt_set,
    output logic evt_kind
);

    localparam int unsigned STAB_W   = clog2(STABLE_LEN);
    localparam int unsigned HOLD_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int unsigned HOLD_W   = clog2(HOLD_MAX);

    localparam logic [STAB_W-1:0] STAB_LAST   = STAB_W'(STABLE_LEN - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_TICKS - 1);

    logic              sync1_q;
    logic              sync_q;
    logic              level_q;
    logic [STAB_W-1:0] stab_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    chan_state_e       state_q;

    logic flip_c;
    logic rise_c;
    logic fall_c;

    assign level = level_q;

    // Decode level edges and the event request for the current tick.
    always_comb begin
        flip_c   = sample_tick && (sync_q != level_q) && (stab_cnt_q == STAB_LAST);
        rise_c   = flip_c && !level_q;
        fall_c   = flip_c && level_q;
        evt_set  = 1'b0;
        evt_kind = EVT_PRESS;
        if (rise_c && (state_q == ST_IDLE)) begin
            evt_set = 1'b1;
        end else if (sample_tick && repeat_en && !fall_c) begin
            if (((state_q == ST_HOLD) && (hold_cnt_q == HOLD_LAST)) ||
                ((state_q == ST_REPEAT) && (hold_cnt_q == REPEAT_LAST))) begin
                evt_set  = 1'b1;
                evt_kind = EVT_REPEAT;
            end
        end
    end

    // Synchroniser, stability counter, channel FSM and hold counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= 1'b0;
            sync_q     <= 1'b0;
            level_q    <= 1'b0;
            stab_cnt_q <= '0;
            hold_cnt_q <= '0;
            state_q    <= ST_IDLE;
        end else begin
            sync1_q <= raw;
            sync_q  <= sync1_q;
            if (sample_tick) begin
                if (sync_q == level_q) begin
                    stab_cnt_q <= '0;
                end else if (stab_cnt_q == STAB_LAST) begin
                    level_q    <= ~level_q;
                    stab_cnt_q <= '0;
                end else begin
                    stab_cnt_q <= stab_cnt_q + STAB_W'(1);
                end

                if (fall_c) begin
                    state_q <= ST_IDLE;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (rise_c) begin
                                hold_cnt_q <= '0;
                                state_q    <= ST_HOLD;
                            end
                        end
                        ST_HOLD: begin
                            if (repeat_en) begin
                                if (hold_cnt_q == HOLD_LAST) begin
                                    hold_cnt_q <= '0;
                                    state_q    <= ST_REPEAT;
                                end else begin
                                    hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                                end
                            end
                        end
                        ST_REPEAT: begin
                            if (repeat_en) begin
                                if (hold_cnt_q == REPEAT_LAST) begin
                                    hold_cnt_q <= '0;
                                end else begin
                                    hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                                end
                            end
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/btn_event_ctrl.sv
// Front-panel button controller: shared sample prescaler, NUM_BTN debounce channels,
// pending-event registers with overrun tracking, fixed-priority arbiter and output slot.
module btn_event_ctrl
    import btn_pkg::*;
#(
    parameter int unsigned NUM_BTN      = 5,
    parameter int unsigned SAMPLE_DIV   = 100000,
    parameter int unsigned STABLE_LEN   = 11,
    parameter int unsigned HOLD_TICKS   = 50,
    parameter int unsigned REPEAT_TICKS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_BTN-1:0]   btn_raw,
    input  logic                 repeat_en,
    output logic [NUM_BTN-1:0]   btn_level,
    output logic                 sample_tick,
    btn_event_ctrl_if.master     evt_if,
    output logic [NUM_BTN-1:0]   overrun,
    input  logic                 ovr_clr
);

    localparam int unsigned ID_W  = clog2(NUM_BTN);
    localparam int unsigned DIV_W = clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [NUM_BTN-1:0] pend_q, pend_d;
    logic [NUM_BTN-1:0] kind_q, kind_d;
    logic [NUM_BTN-1:0] overrun_q, overrun_d;
    logic               valid_q, valid_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               rep_q, rep_d;

    logic [NUM_BTN-1:0] set_c;
    logic [NUM_BTN-1:0] evt_kind_c;
    logic [NUM_BTN-1:0] grant_c;
    logic [NUM_BTN-1:0] keep_c;
    logic [ID_W-1:0]    grant_id_c;
    logic               slot_free_c;
    logic               capture_c;

    assign sample_tick       = (div_cnt_q == DIV_LAST);
    assign overrun           = overrun_q;
    assign evt_if.evt_valid  = valid_q;
    assign evt_if.evt_id     = id_q;
    assign evt_if.evt_repeat = rep_q;

    // One debounce/repeat channel per button.
    for (genvar g = 0; g < int'(NUM_BTN); g++) begin : g_chan
        btn_debounce_chan #(
            .STABLE_LEN  (STABLE_LEN),
            .HOLD_TICKS  (HOLD_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .raw        (btn_raw[g]),
            .sample_tick(sample_tick),
            .repeat_en  (repeat_en),
            .level      (btn_level[g]),
            .evt_set    (set_c[g]),
            .evt_kind   (evt_kind_c[g])
        );
    end

    // Prescaler, lowest-index arbitration, pending/overrun update and output slot.
    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);

        slot_free_c = !valid_q || evt_if.evt_ready;
        capture_c   = slot_free_c && (|pend_q);
        grant_id_c  = '0;
        for (int i = int'(NUM_BTN) - 1; i >= 0; i--) begin
            if (pend_q[i]) grant_id_c = ID_W'(i);
        end
        grant_c = capture_c ? (NUM_BTN'(1) << grant_id_c) : '0;

        // A bit still occupied after this edge's capture cannot accept a new event.
        keep_c    = pend_q & ~grant_c;
        pend_d    = keep_c | set_c;
        kind_d    = (kind_q & ~(set_c & ~keep_c)) | (evt_kind_c & set_c & ~keep_c);
        overrun_d = (ovr_clr ? '0 : overrun_q) | (set_c & keep_c);

        valid_d = valid_q;
        id_d    = id_q;
        rep_d   = rep_q;
        if (slot_free_c) begin
            valid_d = |pend_q;
            if (capture_c) begin
                id_d  = grant_id_c;
                rep_d = |(kind_q & grant_c);
            end
        end
    end

    // State registers for the shared logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q <= '0;
            pend_q    <= '0;
            kind_q    <= '0;
            overrun_q <= '0;
            valid_q   <= 1'b0;
            id_q      <= '0;
            rep_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            pend_q    <= pend_d;
            kind_q    <= kind_d;
            overrun_q <= overrun_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
            rep_q     <= rep_d;
        end
    end

endmodule

// File: doc/btn_event_ctrl.md
Name: btn_event_ctrl

Overview:
Front-panel button controller that debounces NUM_BTN raw push-button inputs through one shared sample prescaler. It turns debounced presses into press and auto-repeat events and arbitrates them onto a single valid/ready event port. It sits between the board button pins and the game/control FSM, and replaces per-button fixed flip-flop chains with one parameterised, scheduled block.

Parameters:
NUM_BTN, 5, number of button inputs (index 0 = highest priority)
SAMPLE_DIV, 100000, clk cycles per sample tick (>=2)
STABLE_LEN, 11, consecutive differing sample ticks required to change a debounced level (>=1)
HOLD_TICKS, 50, sample ticks a button must be held before the first repeat (>=1)
REPEAT_TICKS, 10, sample ticks between successive repeats (>=1)
ID_W, clog2(NUM_BTN) min 1, width of event id (derived, not overridden)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  asynchronous, active-low reset
btn_raw  in  NUM_BTN  asynchronous raw button pins, 1 = pressed
repeat_en  in  1  enables auto-repeat generation
btn_level  out  NUM_BTN  debounced button levels
sample_tick  out  1  one-cycle strobe, prescaler wrap
evt_valid  out  1  event available
evt_id  out  ID_W  index of the button that produced the event
evt_repeat  out  1  0 = initial press, 1 = auto-repeat
evt_ready  in  1  consumer accepts event
overrun  out  NUM_BTN  sticky: event lost on that button
ovr_clr  in  1  synchronous clear of overrun

Behaviour:
- Reset (rst=0, async): prescaler=0, synchronisers=0, btn_level=0, all stability/hold counters=0, all channel FSMs IDLE, pending=0, evt_valid=0, evt_id=0, evt_repeat=0, overrun=0, sample_tick=0.
- Synchroniser: 2-FF synchroniser per bit on btn_raw. Its output is the channel's sync value.
- Prescaler: counts 0..SAMPLE_DIV-1 and wraps. sample_tick=1 in the cycle the count equals SAMPLE_DIV-1. All channel updates below occur only on sample_tick cycles.
- Debounce, per channel, evaluated on each tick:
  - sync==level: stab_cnt=0.
  - sync!=level and stab_cnt==STABLE_LEN-1: level toggles, stab_cnt=0.
  - otherwise: stab_cnt++.
  - Net effect: a level change needs STABLE_LEN consecutive differing ticks.
- Channel FSM, IDLE/HOLD/REPEAT:
  - IDLE: a level rise sets pend[i] with kind=press, clears hold_cnt, and moves to HOLD.
  - HOLD, on each tick with repeat_en=1: hold_cnt++. When hold_cnt==HOLD_TICKS-1, set pend[i] with kind=repeat, clear hold_cnt, and move to REPEAT.
  - REPEAT, on each tick with repeat_en=1: hold_cnt++. When hold_cnt==REPEAT_TICKS-1, set pend[i] with kind=repeat and clear hold_cnt.
  - repeat_en=0 in HOLD or REPEAT: hold_cnt is frozen and no repeats are generated.
  - A level fall in any state returns the FSM to IDLE. An existing pend[i] is kept.
- Pending set while pend[i]=1 and not captured in the same cycle: the new event is dropped, overrun[i]=1 (sticky), and the stored kind is unchanged.
- Output slot:
  - The slot is free when evt_valid=0, or when evt_valid&evt_ready in the current cycle.
  - When the slot is free and pend!=0, capture the lowest-index pending bit into evt_id/evt_repeat, set evt_valid, and clear that pend bit, all on the same edge.
  - This allows back-to-back events with no bubble.
  - If the capture clear and a new set hit the same bit on the same edge, the set wins: the bit remains pending and no overrun is raised.
- Handshake: while evt_valid=1 and evt_ready=0, evt_id and evt_repeat are held stable. evt_valid drops after a handshake only if pend==0.
- ovr_clr=1 clears all overrun bits. If a set and a clear of overrun occur in the same cycle, the set wins.
- Latency:
  - Raw edge to btn_level change: 2 clk + between (STABLE_LEN-1)*SAMPLE_DIV+1 and STABLE_LEN*SAMPLE_DIV clk.
  - Level rise to pend: same edge as the level update.
  - pend to evt_valid: 1 clk.
- Reset asserted mid-operation aborts everything immediately. Pending and in-flight events are discarded.

Decomposition:
- Package btn_pkg holds:
  - the channel state enum (ST_IDLE, ST_HOLD, ST_REPEAT);
  - the EVT_PRESS/EVT_REPEAT kind constants;
  - a clog2 function used to derive ID_W and counter widths.
- Sub-module btn_debounce_chan, generated NUM_BTN times, contains:
  - the synchroniser, stability counter, FSM and hold counter;
  - inputs: clk, rst, raw, sample_tick, repeat_en;
  - outputs: level, evt_set, evt_kind.
- The top level holds the prescaler, pending/kind registers, overrun, arbiter and output slot.

Test Plan:
All cases use SAMPLE_DIV=4, STABLE_LEN=3, HOLD_TICKS=4, REPEAT_TICKS=2, NUM_BTN=5.
1. Reset state: hold rst=0 with btn_raw=5'b11111 -> all outputs 0. Release rst -> sample_tick pulses every 4th clk.
2. Bounce rejection: toggle btn_raw[2] every 2 clk for 40 clk, then hold it at 1 -> btn_level[2] stays 0 during bouncing. It rises within 2+12 clk of stabilising, then evt_valid=1 with evt_id=2, evt_repeat=0.
3. Priority: raise btn_raw[4] and btn_raw[1] together, evt_ready=1 -> events in order id=1, then id=4 on consecutive cycles with no bubble.
4. Auto-repeat: hold btn 0 with repeat_en=1 and evt_ready=1 -> one press event, a repeat event 4 ticks later, then a repeat every 2 ticks. Release -> no further events. Repeat the run with repeat_en=0 -> press event only.
5. Backpressure/overrun: evt_ready=0, press btn 3 twice with full debounce between presses -> the first event is held in the slot and the second becomes pending with overrun[3]=0. A third press sets overrun[3]=1. ovr_clr=1 -> overrun[3]=0.
6. Reset mid-hold: assert rst while in REPEAT with evt_valid=1 -> evt_valid=0 and pend cleared immediately. After release with the button still held -> a fresh press event (evt_repeat=0) after full debounce.
